// File: rtl/cache_l1_nway.sv
// N-way set-associative write-back, write-allocate L1 data cache with age-based LRU.
// CPU side uses a req/done handshake; memory side moves one word per req/ack.
module cache_l1_nway #(
  parameter int ADDR_W          = 7,
  parameter int DATA_W          = 16,
  parameter int WAYS            = 2,
  parameter int SETS_LOG2       = 1,
  parameter int LINE_WORDS_LOG2 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [DATA_W-1:0] q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SETS  = 1 << SETS_LOG2;
  localparam int WORDS = 1 << LINE_WORDS_LOG2;
  localparam int TAG_W = ADDR_W - SETS_LOG2 - LINE_WORDS_LOG2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [TAG_W-1:0]           tag_t;
  typedef logic [SETS_LOG2-1:0]       idx_t;
  typedef logic [LINE_WORDS_LOG2-1:0] off_t;
  typedef logic [WAY_W-1:0]           way_t;
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] line_mem [WAYS][SETS][WORDS];
  tag_t              tag_mem  [WAYS][SETS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  way_t              age      [SETS][WAYS];

  logic [ADDR_W-1:0] r_addr;
  logic              r_wren;
  logic [DATA_W-1:0] r_data;
  way_t              vic;
  off_t              cnt;
  off_t              cnt_nxt;

  tag_t a_tag, r_tag;
  idx_t a_idx, r_idx;
  off_t a_off, r_off;

  assign a_tag   = addr[ADDR_W-1 -: TAG_W];
  assign a_idx   = addr[LINE_WORDS_LOG2 +: SETS_LOG2];
  assign a_off   = addr[LINE_WORDS_LOG2-1:0];
  assign r_tag   = r_addr[ADDR_W-1 -: TAG_W];
  assign r_idx   = r_addr[LINE_WORDS_LOG2 +: SETS_LOG2];
  assign r_off   = r_addr[LINE_WORDS_LOG2-1:0];
  assign cnt_nxt = cnt + off_t'(1);

  logic accept;
  assign accept = req && (state == IDLE);

  logic lk_hit;
  way_t lk_way;
  way_t vc_way;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[a_idx][w] && tag_mem[w][a_idx] == a_tag) begin
        lk_hit = 1'b1;
        lk_way = way_t'(w);
      end
  end

  // Oldest way by default; the descending scan lets the lowest invalid way win.
  always_comb begin
    vc_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[a_idx][w] == way_t'(WAYS - 1)) vc_way = way_t'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[a_idx][w]) vc_way = way_t'(w);
  end

  logic lru_en;
  idx_t lru_set;
  way_t lru_way;

  always_comb begin
    lru_en  = (accept && lk_hit) || (state == DONE);
    lru_set = (state == DONE) ? r_idx : a_idx;
    lru_way = (state == DONE) ? vic : lk_way;
  end

  logic              wr_en;
  way_t              wr_way;
  idx_t              wr_set;
  off_t              wr_off;
  logic [DATA_W-1:0] wr_val;

  always_comb begin
    wr_en  = 1'b0;
    wr_way = vic;
    wr_set = r_idx;
    wr_off = cnt;
    wr_val = mem_rdata;
    case (state)
      IDLE: if (accept && lk_hit && wren) begin
        wr_en  = 1'b1;
        wr_way = lk_way;
        wr_set = a_idx;
        wr_off = a_off;
        wr_val = data;
      end
      FILL: wr_en = mem_req && mem_ack;
      DONE: if (r_wren) begin
        wr_en  = 1'b1;
        wr_off = r_off;
        wr_val = r_data;
      end
      default: ;
    endcase
  end

  // NOTE: line and tag storage carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (wr_en) line_mem[wr_way][wr_set][wr_off] <= wr_val;
    if (state == DONE) tag_mem[vic][r_idx] <= r_tag;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      q         <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_addr    <= '0;
      r_wren    <= 1'b0;
      r_data    <= '0;
      vic       <= '0;
      cnt       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) age[s][w] <= way_t'(w);
      end
    end else begin
      done <= 1'b0;

      if (lru_en)
        for (int w = 0; w < WAYS; w++)
          if (way_t'(w) == lru_way)
            age[lru_set][w] <= '0;
          else if (age[lru_set][w] < age[lru_set][lru_way])
            age[lru_set][w] <= age[lru_set][w] + way_t'(1);

      case (state)
        IDLE: if (accept) begin
          if (lk_hit) begin
            done <= 1'b1;
            hit  <= 1'b1;
            q    <= wren ? data : line_mem[lk_way][a_idx][a_off];
            if (wren) dirty[a_idx][lk_way] <= 1'b1;
          end else begin
            busy    <= 1'b1;
            hit     <= 1'b0;
            r_addr  <= addr;
            r_wren  <= wren;
            r_data  <= data;
            vic     <= vc_way;
            cnt     <= '0;
            mem_req <= 1'b1;
            if (valid[a_idx][vc_way] && dirty[a_idx][vc_way]) begin
              state     <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[vc_way][a_idx], a_idx, off_t'(0)};
              mem_wdata <= line_mem[vc_way][a_idx][off_t'(0)];
            end else begin
              state    <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= {a_tag, a_idx, off_t'(0)};
            end
          end
        end
        WB: if (mem_ack) begin
          if (cnt == off_t'(WORDS - 1)) begin
            state    <= FILL;
            cnt      <= '0;
            mem_we   <= 1'b0;
            mem_addr <= {r_tag, r_idx, off_t'(0)};
          end else begin
            cnt       <= cnt_nxt;
            mem_addr  <= {tag_mem[vic][r_idx], r_idx, cnt_nxt};
            mem_wdata <= line_mem[vic][r_idx][cnt_nxt];
          end
        end
        FILL: if (mem_ack) begin
          if (cnt == off_t'(WORDS - 1)) begin
            state   <= DONE;
            mem_req <= 1'b0;
          end else begin
            cnt      <= cnt_nxt;
            mem_addr <= {r_tag, r_idx, cnt_nxt};
          end
        end
        DONE: begin
          valid[r_idx][vic] <= 1'b1;
          dirty[r_idx][vic] <= r_wren;
          done              <= 1'b1;
          hit               <= 1'b0;
          q                 <= r_wren ? r_data : line_mem[vic][r_idx][r_off];
          busy              <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
